alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present on ctrl/x/y.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 ctrl  input  4  operation code per REQ-012.
REQ-007 x  input  8  operand A; x[2:0] is the shift amount for codes 0111/1000.
REQ-008 y  input  8  operand B.
REQ-009 out_valid  output  1  result on out/carry is valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  8  result; carry  output  1  signed overflow-style carry.

Function
REQ-012 Opcodes SHALL be: 0000 x+y; 0001 x-y (x + (~y+1)); 0010 x&y; 0011 x|y; 0100 ~x; 0101 x^y; 0110 ~(x|y); 0111 y<<x[2:0]; 1000 y>>x[2:0] (logical); 1001 {x[7],x[7:1]}; 1010 {x[6:0],x[7]}; 1011 {x[0],x[7:1]}; 1100 out=8'd1 if x==y else 8'd0; 1101/1110/1111 out=8'd0.
REQ-013 For 0000, carry SHALL be bit 8 of the 9-bit sum {x[7],x}+{y[7],y}; for 0001, bit 8 of {x[7],x}+{n[7],n} with n=~y+1 (8-bit); for all other opcodes carry=0.
REQ-014 States SHALL be IDLE, SHIFT, DONE; one-hot or binary encoding is implementation choice.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with in_valid=1 and in_ready=1, latching ctrl, x, y.
REQ-016 On acceptance of a non-shift opcode (not 0111/1000), the block SHALL compute the result and enter DONE at that edge (out_valid=1 one cycle after acceptance).
REQ-017 On acceptance of 0111/1000, the block SHALL load y into a working register and a 3-bit counter with x[2:0]; if x[2:0]=0 it enters DONE directly, else SHIFT.
REQ-018 In SHIFT, each cycle SHALL shift the working register one bit (left for 0111, right for 1000, zero fill) and decrement the counter; on the edge where the counter goes 1->0 the block enters DONE.
REQ-019 Latency from acceptance edge to first out_valid=1 cycle SHALL be 1 cycle for non-shift ops and 1+x[2:0] cycles for variable shifts (max 8).
REQ-020 In DONE, out_valid=1 and out/carry SHALL be held stable until an edge with out_ready=1, after which the block returns to IDLE (out_valid=0, in_ready=1 the next cycle).
REQ-021 out_ready while out_valid=0 SHALL have no effect; in_valid while in_ready=0 SHALL be ignored (request not captured).
REQ-022 Inputs ctrl/x/y changing after acceptance SHALL NOT affect the in-flight result.
REQ-023 Minimum throughput SHALL be one request per 3 cycles for non-shift ops (accept, DONE, IDLE).
REQ-024 out and carry SHALL be driven from registers only (no combinational path from inputs).

Reset
REQ-025 While rst_n=0, state SHALL be IDLE, out=8'd0, carry=0, out_valid=0, in_ready=1 (after reset release), counter=0.
REQ-026 Asserting rst_n=0 in SHIFT or DONE SHALL immediately abort the operation; the result is discarded and never presented.

Verification
REQ-027 Add: ctrl=0000, x=8'h7F, y=8'h01 accepted -> next cycle out_valid=1, out=8'h80, carry=0; x=8'h80, y=8'h80 -> out=8'h00, carry=1.
REQ-028 Sub: ctrl=0001, x=8'h05, y=8'h07 -> out=8'hFE, carry=1; ctrl=1100, x=y=8'h3C -> out=8'h01, carry=0.
REQ-029 Shift latency: ctrl=0111, x=8'h05, y=8'h03 -> out_valid rises exactly 6 cycles after acceptance with out=8'h60; ctrl=1000, x=8'h00, y=8'hA5 -> 1 cycle, out=8'hA5.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-031 Reset mid-op: ctrl=1000, x=8'h07 accepted, rst_n=0 after 3 cycles -> out=0, out_valid=0 immediately; after release in_ready=1 and no stale result appears.
REQ-032 Rotates/SRA/reserved: x=8'h81 with 1001 -> 8'hC0, 1010 -> 8'h03, 1011 -> 8'hC0, 1101/1110/1111 -> 8'h00, carry=0.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked 8-bit ALU with single-cycle ops and iterative variable shifts
module alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ctrl,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       carry
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [7:0]  work_q, work_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  out_q, out_d;
    logic        carry_q, carry_d;

    logic [7:0]  neg_y;
    logic [8:0]  sum_add;
    logic [8:0]  sum_sub;
    logic [7:0]  res;
    logic        res_c;
    logic [7:0]  shifted;
    logic        is_shift;

    always_comb begin
        neg_y   = ~y + 8'd1;
        sum_add = {x[7], x} + {y[7], y};
        sum_sub = {x[7], x} + {neg_y[7], neg_y};
        res     = 8'd0;
        res_c   = 1'b0;
        case (ctrl)
            4'b0000: begin res = sum_add[7:0]; res_c = sum_add[8]; end
            4'b0001: begin res = sum_sub[7:0]; res_c = sum_sub[8]; end
            4'b0010: res = x & y;
            4'b0011: res = x | y;
            4'b0100: res = ~x;
            4'b0101: res = x ^ y;
            4'b0110: res = ~(x | y);
            4'b1001: res = {x[7], x[7:1]};
            4'b1010: res = {x[6:0], x[7]};
            4'b1011: res = {x[0], x[7:1]};
            4'b1100: res = (x == y) ? 8'd1 : 8'd0;
            default: res = 8'd0;
        endcase
    end

    assign is_shift = (ctrl == 4'b0111) || (ctrl == 4'b1000);
    assign shifted  = dir_q ? (work_q >> 1) : (work_q << 1);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift) begin
                        dir_d  = ctrl[3];
                        work_d = y;
                        cnt_d  = x[2:0];
                        if (x[2:0] == 3'd0) begin
                            out_d   = y;
                            carry_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        out_d   = res;
                        carry_d = res_c;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 3'd1;
                // Final step publishes the shifted value directly into the output register
                if (cnt_q == 3'd1) begin
                    out_d   = shifted;
                    carry_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            work_q  <= 8'd0;
            cnt_q   <= 3'd0;
            out_q   <= 8'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       carry;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [8:0] exp_q[$];

    alu_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl     (ctrl),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry, out}
    function automatic logic [8:0] model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] n;
        logic [8:0] s;
        n = ~b + 8'd1;
        case (c)
            4'd0:  begin s = {a[7], a} + {b[7], b}; return s; end
            4'd1:  begin s = {a[7], a} + {n[7], n}; return s; end
            4'd2:  return {1'b0, a & b};
            4'd3:  return {1'b0, a | b};
            4'd4:  return {1'b0, ~a};
            4'd5:  return {1'b0, a ^ b};
            4'd6:  return {1'b0, ~(a | b)};
            4'd7:  return {1'b0, b << a[2:0]};
            4'd8:  return {1'b0, b >> a[2:0]};
            4'd9:  return {1'b0, a[7], a[7:1]};
            4'd10: return {1'b0, a[6:0], a[7]};
            4'd11: return {1'b0, a[0], a[7:1]};
            4'd12: return (a == b) ? 9'd1 : 9'd0;
            default: return 9'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        logic [8:0] e;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " result"}, {23'd0, carry, out}, {23'd0, e});
        end else begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0 + exp_q.size());
        end
    endtask

    task automatic run(input string tag, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat);
        @(negedge clk);
        ctrl = c; x = a; y = b; in_valid = 1'b1;
        exp_q.push_back(model(c, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        ctrl = 4'($urandom); x = 8'($urandom); y = 8'($urandom);
        wait_result(tag, exp_lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " back to idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [7:0] held;
        logic       seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl = 4'd0; x = 8'd0; y = 8'd0;
        repeat (3) @(negedge clk);
        check("reset out", {23'd0, carry, out}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        run("add 7f+01", 4'd0, 8'h7F, 8'h01, 1);
        run("add 80+80", 4'd0, 8'h80, 8'h80, 1);
        run("sub 05-07", 4'd1, 8'h05, 8'h07, 1);
        run("eq 3c",     4'd12, 8'h3C, 8'h3C, 1);
        run("eq diff",   4'd12, 8'h3C, 8'h3D, 1);
        run("and",       4'd2, 8'hF0, 8'h3C, 1);
        run("or",        4'd3, 8'hA0, 8'h05, 1);
        run("not",       4'd4, 8'h5A, 8'h00, 1);
        run("xor",       4'd5, 8'hFF, 8'h0F, 1);
        run("nor",       4'd6, 8'h12, 8'h40, 1);
        run("shl 5",     4'd7, 8'h05, 8'h03, 6);
        run("shr 0",     4'd8, 8'h00, 8'hA5, 1);
        run("shr 3",     4'd8, 8'h03, 8'hF0, 4);
        run("shl 7",     4'd7, 8'hFF, 8'h01, 8);
        run("sra",       4'd9, 8'h81, 8'h00, 1);
        run("rol",       4'd10, 8'h81, 8'h00, 1);
        run("ror",       4'd11, 8'h81, 8'h00, 1);
        run("rsv d",     4'd13, 8'h81, 8'hFF, 1);
        run("rsv e",     4'd14, 8'h81, 8'hFF, 1);
        run("rsv f",     4'd15, 8'h81, 8'hFF, 1);

        // Backpressure: hold result while a competing request is presented
        @(negedge clk);
        ctrl = 4'd0; x = 8'h12; y = 8'h34; in_valid = 1'b1;
        exp_q.push_back(model(4'd0, 8'h12, 8'h34));
        @(posedge clk); #1;
        ctrl = 4'd0; x = 8'h01; y = 8'h01;
        wait_result("bp", 1);
        held = out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold", {22'd0, in_ready, out_valid, out}, {22'd0, 1'b0, 1'b1, held});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", {30'd0, out_valid, in_ready}, 32'b01);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("bp ignored request", {31'd0, seen}, 32'd0);

        // Reset during a long shift
        @(negedge clk);
        ctrl = 4'd8; x = 8'h07; y = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out", {22'd0, out_valid, carry, out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no stale result", {31'd0, seen}, 32'd0);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
